// File: rtl/axil_master.sv
// AXI4-Lite initiator: turns single commands into one AXI-Lite read or write
// and hands back one response; at most one transaction is outstanding.
module axil_master #(
  parameter int unsigned ADDR_WIDTH = 40,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [2:0]  PROT       = 3'b000
) (
  input  logic                    axi_aclk,
  input  logic                    axi_areset,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_write,

  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,

  output logic                    busy
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RSP} state_t;

  state_t                  state_q, state_d;
  logic                    aw_pend_q, aw_pend_d;
  logic                    w_pend_q, w_pend_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;

  always_comb begin
    state_d   = state_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          rdata_d = '0;
          resp_d  = '0;
          if (cmd_write) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
        // AW and W retire independently; leave only once neither is pending
        aw_pend_d = aw_pend_q & ~m_axi_awready;
        w_pend_d  = w_pend_q & ~m_axi_wready;
        if (!aw_pend_d && !w_pend_d) state_d = WRESP;
      end
      WRESP: begin
        if (m_axi_bvalid) begin
          resp_d  = m_axi_bresp;
          state_d = RSP;
        end
      end
      READ: begin
        if (m_axi_arready) state_d = RDATA;
      end
      RDATA: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          resp_d  = m_axi_rresp;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q   <= IDLE;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  // Every valid/ready is a pure function of registered state
  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign m_axi_awvalid = aw_pend_q;
  assign m_axi_wvalid  = w_pend_q;
  assign m_axi_bready  = (state_q == WRESP);
  assign m_axi_arvalid = (state_q == READ);
  assign m_axi_rready  = (state_q == RDATA);
  assign rsp_valid     = (state_q == RSP);

  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awprot  = PROT;
  assign m_axi_arprot  = PROT;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_write     = write_q;

endmodule

// File: tb/tb_axil_master.sv
// Bench for axil_master: a small register-file responder model with
// programmable ready/response delays, a response scoreboard and protocol monitor.
module tb_axil_master;
  localparam int AW = 40;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]    m_axi_awprot, m_axi_arprot;
  logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]    m_axi_wstrb;
  logic [1:0]    m_axi_bresp, m_axi_rresp;
  logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic          m_axi_rvalid, m_axi_rready, busy;

  axil_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROT(3'b000)) dut (
    .axi_aclk(clk), .axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Responder model: four 32-bit registers, reset to known contents
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0] s_resp = 2'b00;
  logic spur_b = 1'b0, spur_r = 1'b0;
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic aw_got, w_got, ar_got, bvalid_s, rvalid_s;
  logic [AW-1:0] aw_addr_s, ar_addr_s;
  logic [DW-1:0] w_data_s, rdata_s;
  logic [3:0] w_strb_s;
  logic [1:0] bresp_s, rresp_s;
  logic [DW-1:0] mem [4];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  assign m_axi_awready = m_axi_awvalid && !aw_got && (aw_cnt >= aw_dly);
  assign m_axi_wready  = m_axi_wvalid && !w_got && (w_cnt >= w_dly);
  assign m_axi_arready = m_axi_arvalid && !ar_got && (ar_cnt >= ar_dly);
  assign m_axi_bvalid  = bvalid_s | spur_b;
  assign m_axi_bresp   = bresp_s;
  assign m_axi_rvalid  = rvalid_s | spur_r;
  assign m_axi_rdata   = rdata_s;
  assign m_axi_rresp   = rresp_s;

  always @(posedge clk) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      bvalid_s <= 1'b0; rvalid_s <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_addr_s <= '0; ar_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0;
      rdata_s <= '0; bresp_s <= '0; rresp_s <= '0;
      mem[0] <= 32'hDEADBEEF; mem[1] <= 32'h76543210; mem[2] <= '0; mem[3] <= '0;
    end else begin
      if (m_axi_awvalid && !aw_got) aw_cnt <= m_axi_awready ? 0 : aw_cnt + 1;
      if (m_axi_awvalid && m_axi_awready) begin aw_got <= 1'b1; aw_addr_s <= m_axi_awaddr; end
      if (m_axi_wvalid && !w_got) w_cnt <= m_axi_wready ? 0 : w_cnt + 1;
      if (m_axi_wvalid && m_axi_wready) begin
        w_got <= 1'b1; w_data_s <= m_axi_wdata; w_strb_s <= m_axi_wstrb;
      end
      if (aw_got && w_got) begin
        if (b_cnt >= b_dly) begin
          if (s_resp == 2'b00) mem[aw_addr_s[3:2]] <= merge(mem[aw_addr_s[3:2]], w_data_s, w_strb_s);
          bvalid_s <= 1'b1; bresp_s <= s_resp;
          aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
        end else b_cnt <= b_cnt + 1;
      end
      if (bvalid_s && m_axi_bready) bvalid_s <= 1'b0;
      if (m_axi_arvalid && !ar_got) ar_cnt <= m_axi_arready ? 0 : ar_cnt + 1;
      if (m_axi_arvalid && m_axi_arready) begin ar_got <= 1'b1; ar_addr_s <= m_axi_araddr; end
      if (ar_got) begin
        if (r_cnt >= r_dly) begin
          rvalid_s <= 1'b1; rdata_s <= mem[ar_addr_s[3:2]]; rresp_s <= s_resp;
          ar_got <= 1'b0; r_cnt <= 0;
        end else r_cnt <= r_cnt + 1;
      end
      if (rvalid_s && m_axi_rready) rvalid_s <= 1'b0;
    end
  end

  // Protocol monitor: payload stability, valid drop after handshake, 1-cycle response latency
  logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bh, p_rh;
  logic [AW-1:0] p_awa, p_ara;
  logic [DW-1:0] p_wd;
  always @(negedge clk) begin
    #1;
    if (rst) begin
      {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bh, p_rh} = '0;
    end else begin
      if (p_awv && !p_awr) check("aw_hold", {m_axi_awvalid, m_axi_awaddr}, {1'b1, p_awa});
      if (p_awv && p_awr)  check("aw_drop", m_axi_awvalid, 1'b0);
      if (p_wv && !p_wr)   check("w_hold", {m_axi_wvalid, m_axi_wdata}, {1'b1, p_wd});
      if (p_wv && p_wr)    check("w_drop", m_axi_wvalid, 1'b0);
      if (p_arv && !p_arr) check("ar_hold", {m_axi_arvalid, m_axi_araddr}, {1'b1, p_ara});
      if (p_arv && p_arr)  check("ar_drop", m_axi_arvalid, 1'b0);
      if (p_bh || p_rh)    check("rsp_latency", rsp_valid, 1'b1);
      p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awa = m_axi_awaddr;
      p_wv = m_axi_wvalid; p_wr = m_axi_wready; p_wd = m_axi_wdata;
      p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_ara = m_axi_araddr;
      p_bh = m_axi_bvalid && m_axi_bready;
      p_rh = m_axi_rvalid && m_axi_rready;
    end
  end

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic [1:0]    resp;
    int            aw_d, w_d, ar_d, r_d, hold;
    logic [31:0]   exp_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        write;
  } exp_t;

  exp_t sb[$];

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
  task automatic do_cmd(input vec_t t);
    exp_t e;
    int n;
    aw_dly = t.aw_d; w_dly = t.w_d; ar_dly = t.ar_d; r_dly = t.r_d; s_resp = t.resp;
    e.rdata = t.exp_rdata; e.resp = t.resp; e.write = t.write;
    sb.push_back(e);
    cmd_valid = 1'b1; cmd_write = t.write; cmd_addr = t.addr;
    cmd_wdata = t.wdata; cmd_wstrb = t.wstrb;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (t.write) begin
      check("aw_w_start", {m_axi_awvalid, m_axi_wvalid, m_axi_awaddr}, {2'b11, t.addr});
      check("w_payload", {m_axi_wdata, m_axi_wstrb}, {t.wdata, t.wstrb});
      if (t.aw_d == 0 && t.w_d == 0) begin
        @(negedge clk);
        check("bready_next", {m_axi_bready, m_axi_awvalid, m_axi_wvalid}, 3'b100);
      end
    end else begin
      check("ar_start", {m_axi_arvalid, m_axi_araddr}, {1'b1, t.addr});
    end
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    check("rsp_arrives", rsp_valid, 1'b1);
    for (int i = 0; i < t.hold; i++) begin
      check("rsp_held", {rsp_valid, cmd_ready, busy, rsp_resp}, {3'b101, t.resp});
      @(negedge clk);
    end
    if (sb.size() == 0) check("sb_nonempty", rsp_valid, 1'b0);
    else begin
      e = sb.pop_front();
      check("rsp_rdata", rsp_rdata, e.rdata);
      check("rsp_resp", rsp_resp, e.resp);
      check("rsp_write", rsp_write, e.write);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("single_rsp", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v[13];
    vec_t t;
    int   n;
    logic seen;
    //          wr    addr    wdata          strb  resp   aw w ar r hold exp_rdata
    v[0]  = '{1'b1, 40'h8, 32'hCAFEF00D, 4'hF, 2'b00, 0, 0, 0, 0, 0, 32'h0};
    v[1]  = '{1'b0, 40'h0, 32'h0,        4'h0, 2'b00, 0, 0, 0, 0, 0, 32'hDEADBEEF};
    v[2]  = '{1'b0, 40'h4, 32'h0,        4'h0, 2'b00, 0, 0, 0, 0, 0, 32'h76543210};
    v[3]  = '{1'b0, 40'h8, 32'h0,        4'h0, 2'b00, 0, 0, 0, 0, 0, 32'hCAFEF00D};
    v[4]  = '{1'b1, 40'hC, 32'h11223344, 4'h5, 2'b00, 3, 0, 0, 0, 0, 32'h0};
    v[5]  = '{1'b0, 40'hC, 32'h0,        4'h0, 2'b11, 0, 0, 0, 0, 0, 32'h00220044};
    v[6]  = '{1'b1, 40'h0, 32'hFFFFFFFF, 4'hF, 2'b10, 0, 0, 0, 0, 0, 32'h0};
    v[7]  = '{1'b0, 40'h0, 32'h0,        4'h0, 2'b00, 0, 0, 2, 3, 0, 32'hDEADBEEF};
    v[8]  = '{1'b1, 40'h8, 32'h12345678, 4'h3, 2'b00, 0, 2, 0, 0, 0, 32'h0};
    v[9]  = '{1'b0, 40'h8, 32'h0,        4'h0, 2'b00, 0, 0, 0, 0, 0, 32'hCAFE5678};
    v[10] = '{1'b1, 40'h8, 32'hCAFEF00D, 4'hF, 2'b00, 0, 5, 0, 0, 0, 32'h0};
    v[11] = '{1'b0, 40'h8, 32'h0,        4'h0, 2'b00, 0, 0, 0, 0, 0, 32'hCAFEF00D};
    v[12] = '{1'b0, 40'h4, 32'h0,        4'h0, 2'b10, 0, 0, 0, 0, 3, 32'h76543210};

    repeat (3) @(negedge clk);
    check("reset_handshakes", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                               m_axi_bready, m_axi_rready, rsp_valid, busy}, 7'b0);
    check("reset_payload", {m_axi_awaddr, m_axi_wdata, m_axi_wstrb, rsp_rdata, rsp_resp, rsp_write}, '0);
    check("reset_prot", {m_axi_awprot, m_axi_arprot}, 6'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {cmd_ready, busy}, 2'b10);

    for (int i = 0; i < 13; i++) do_cmd(v[i]);

    // Stray bvalid/rvalid while idle must not be acknowledged
    spur_b = 1'b1; spur_r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_resp_ignored", {m_axi_bready, m_axi_rready, busy, rsp_valid}, 4'b0);
    end
    spur_b = 1'b0; spur_r = 1'b0;
    @(negedge clk);

    // Reset while waiting in WRESP abandons the write
    aw_dly = 0; w_dly = 0; b_dly = 10; s_resp = 2'b00;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 40'h8;
    cmd_wdata = 32'h0BADF00D; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!m_axi_bready && n < 20) begin @(negedge clk); n++; end
    check("reached_wresp", m_axi_bready, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_reset_quiet", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                              m_axi_bready, m_axi_rready, rsp_valid, busy}, 7'b0);
    b_dly = 0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("no_rsp_after_abort", seen, 1'b0);
    t = '{1'b0, 40'h4, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 32'h76543210};
    do_cmd(t);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axil_master.md
AXIL_MASTER -- requirements
Module: axil_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 40, AXI-Lite address width.
REQ-002 Parameter DATA_WIDTH, default 32, data width; strobe width is DATA_WIDTH/8.
REQ-003 Parameter PROT, default 3'b000, constant driven on awprot and arprot.
REQ-004 Port axi_aclk, input, 1, sole clock; all logic on its rising edge.
REQ-005 Port axi_areset, input, 1, reset; synchronous, active-high.
REQ-006 Ports cmd_valid in 1, cmd_ready out 1, cmd_write in 1, cmd_addr in ADDR_WIDTH, cmd_wdata in DATA_WIDTH, cmd_wstrb in DATA_WIDTH/8: command channel (1 = write).
REQ-007 Ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out DATA_WIDTH, rsp_resp out 2, rsp_write out 1: response channel.
REQ-008 Ports m_axi_awaddr/awprot/awvalid out, m_axi_awready in; m_axi_wdata/wstrb/wvalid out, m_axi_wready in; m_axi_bresp/bvalid in, m_axi_bready out; m_axi_araddr/arprot/arvalid out, m_axi_arready in; m_axi_rdata/rresp/rvalid in, m_axi_rready out: AXI4-Lite initiator, standard widths.
REQ-009 Port busy, output, 1, high whenever state is not IDLE.

Function
REQ-010 The block SHALL be an AXI4-Lite initiator that is the counterpart of the team's AXI-Lite register-file responder, with at most one transaction outstanding.
REQ-011 The FSM SHALL have states IDLE, WRITE, WRESP, READ, RDATA, RSP.
REQ-012 cmd_ready SHALL equal (state == IDLE); a command is accepted on cmd_valid && cmd_ready, and addr/wdata/wstrb/write are registered on acceptance.
REQ-013 IDLE -> WRITE on an accepted write: the next cycle SHALL assert awvalid and wvalid together with registered awaddr, wdata, wstrb.
REQ-014 In WRITE, awvalid SHALL drop the cycle after awready is sampled high and wvalid the cycle after wready; the two handshakes are independent and may occur in either order or the same cycle.
REQ-015 WRITE -> WRESP once both AW and W handshakes have completed; bready SHALL be high only in WRESP; on bvalid, bresp is captured and the FSM goes to RSP.
REQ-016 IDLE -> READ on an accepted read: arvalid SHALL be high from the next cycle until the arready handshake; then -> RDATA.
REQ-017 rready SHALL be high only in RDATA; on rvalid, rdata and rresp are captured and the FSM goes to RSP.
REQ-018 In RSP, rsp_valid SHALL be high with captured rsp_resp, rsp_write, and rsp_rdata (zero for writes); state is held until rsp_ready, then -> IDLE.
REQ-019 Valid signals SHALL NOT depend combinationally on any ready input, and once asserted SHALL stay high with stable payload until handshake.
REQ-020 Command-to-AXI latency SHALL be exactly 1 cycle; response-to-rsp_valid latency SHALL be exactly 1 cycle; minimum back-to-back command spacing SHALL be 4 cycles for writes with immediate readies.
REQ-021 SLVERR/DECERR responses SHALL be passed through unchanged on rsp_resp and SHALL NOT stall the FSM.
REQ-022 bvalid or rvalid arriving outside WRESP/RDATA SHALL be ignored (ready stays low).

Reset
REQ-023 While axi_areset is high at a clock edge, the FSM SHALL go to IDLE and all valid/ready outputs (awvalid, wvalid, arvalid, bready, rready, rsp_valid) SHALL be 0 on the following cycle.
REQ-024 Registered address/data/rsp payload SHALL reset to 0.
REQ-025 Reset mid-transaction SHALL abandon the transaction with no rsp_valid generated; subsequent commands are accepted normally.

Verification
REQ-026 Write 0x0000_0008 data 0xCAFEF00D strb 0xF, slave readies high -> AW and W same cycle, bready next cycle, rsp_valid with rsp_resp 0, rsp_write 1.
REQ-027 Read 0x0 from the register-file responder -> rsp_rdata 0xDEADBEEF; read 0x4 -> 0x76543210.
REQ-028 Write 0x8 with wready delayed 5 cycles after awready -> awvalid drops after its handshake, wvalid held with stable data, one rsp only; readback of 0x8 returns 0xCAFEF00D.
REQ-029 Read with rvalid rresp 2'b10 and rsp_ready held low 3 cycles -> rsp_valid held, rsp_resp 2'b10, cmd_ready low until rsp_ready.
REQ-030 axi_areset pulsed for 1 cycle while in WRESP -> next cycle all valids/readies 0, busy 0, no rsp_valid; following read of 0x4 returns 0x76543210.
